decade_display_driver: RTL and testbench

Downstream consumer of the 4-bit ripple decade counter. Samples the counter's asynchronous BCD output into the clk domain, rejects ripple transients, and extends the count to two BCD digits by detecting the units 9->0 wrap. Drives a time-multiplexed two-digit seven-segment display and emits a carry pulse for further cascading.

---
 rtl/decade_display_driver.sv | 121 ++++++++++++
 tb/tb_decade_display_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decade_display_driver.sv
// decade_display_driver
//
// Consumes the BCD output of an upstream ripple decade counter. The counter
// output is asynchronous to clk, so it is synchronised and filtered before
// use. A units 9->0 transition extends the count into a tens digit. Both
// digits are shown on a time-multiplexed two-digit seven-segment display.
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-low reset
//   units      4-bit BCD from the upstream counter (asynchronous to clk)
//   tens       registered tens digit, 0..9
//   units_q    filtered, registered units value
//   carry_out  one-cycle pulse when tens wraps 9->0
//   bad_code   high while units_q holds a non-BCD code (10..15)
//   seg        segments {g,f,e,d,c,b,a}, active-high
//   an         one-hot digit enable: 2'b01 units, 2'b10 tens
//
// Parameter:
//   SCAN_DIV   clk cycles each digit stays selected (2..65535)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is blanked.

module decade_display_driver #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] units_q,
  output logic       carry_out,
  output logic       bad_code,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [3:0]  s1_p0;
  logic [3:0]  s2_p1;
  logic        stable_p1;
  logic        wrap_p1;
  logic [15:0] scan_cnt;
  logic        sel;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'b1000000;  // dash for non-BCD codes
    endcase
    return s;
  endfunction

  // Two matching samples in a row mean the ripple has settled; anything
  // shorter is a transient and never reaches units_q.
  assign stable_p1 = (s1_p0 == s2_p1);

  // A wrap is the filtered units value moving from 9 to 0 at this edge.
  // An upstream clear (9 straight to 0) is indistinguishable and counts too.
  assign wrap_p1 = stable_p1 && (units_q == 4'd9) && (s2_p1 == 4'd0);

  always_ff @(posedge clk) begin
    if (!clear) begin
      s1_p0     <= 4'd0;
      s2_p1     <= 4'd0;
      units_q   <= 4'd0;
      tens      <= 4'd0;
      carry_out <= 1'b0;
      scan_cnt  <= 16'd0;
      sel       <= 1'b0;
    end else begin
      // stage p0: first synchroniser flop
      s1_p0 <= units;
      // stage p1: second synchroniser flop
      s2_p1 <= s1_p0;
      // stage p2: filtered capture and tens extension
      if (stable_p1) begin
        units_q <= s2_p1;
      end
      carry_out <= wrap_p1 && (tens == 4'd9);
      if (wrap_p1) begin
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= 16'd0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  assign bad_code = (units_q > 4'd9);

  // Display decode is purely from registered state so seg and an move on
  // the same edge as the digit select.
  always_comb begin
    an  = sel ? 2'b10 : 2'b01;
    seg = sel ? bcd_to_seg(tens) : bcd_to_seg(units_q);
`ifdef LEADING_ZERO_BLANK_EN
    if (sel && (tens == 4'd0)) begin
      seg = 7'b0000000;
    end
`else
`endif
  end

endmodule

// File: tb/tb_decade_display_driver.sv
module tb_decade_display_driver;

  localparam int SIG_TENS  = 0;
  localparam int SIG_UQ    = 1;
  localparam int SIG_CARRY = 2;
  localparam int SIG_BAD   = 3;
  localparam int SIG_SEG   = 4;
  localparam int SIG_AN    = 5;

`ifdef LEADING_ZERO_BLANK_EN
  localparam int TENS0_SEG = 'h00;
`else
  localparam int TENS0_SEG = 'h3F;
`endif

  logic       clk;
  logic       clear;
  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] units_q;
  logic       carry_out;
  logic       bad_code;
  logic [6:0] seg;
  logic [1:0] an;

  decade_display_driver #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .clear     (clear),
    .units     (units),
    .tens      (tens),
    .units_q   (units_q),
    .carry_out (carry_out),
    .bad_code  (bad_code),
    .seg       (seg),
    .an        (an)
  );

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string nm;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   rel0  = 0;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_sig(input int sig);
    case (sig)
      SIG_TENS:  return int'(tens);
      SIG_UQ:    return int'(units_q);
      SIG_CARRY: return int'(carry_out);
      SIG_BAD:   return int'(bad_code);
      SIG_SEG:   return int'(seg);
      default:   return int'(an);
    endcase
  endfunction

  // Scoreboard monitor: on every falling edge, compare and retire every
  // expectation due at the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        total++;
        if (get_sig(q[i].sig) != q[i].val) begin
          bad++;
          $display("FAIL %s cycle=%0d got=%0h want=%0h", q[i].nm, cyc,
                   get_sig(q[i].sig), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  function automatic void ex(input int d, input string nm, input int sig, input int val);
    exp_t e;
    e.at  = cyc + d;
    e.sig = sig;
    e.val = val;
    e.nm  = nm;
    q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until the scan phase (edges since reset release) is a multiple of 8.
  task automatic align0();
    while (((cyc - rel0) % 8) != 0) tick(1);
  endtask

  task automatic wrap();
    units = 4'd9;
    tick(4);
    units = 4'd0;
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0;
    units = 4'd7;

    // Reset held for two edges
    tick(2);
    total++;
    if (tens !== 4'd0) begin
      bad++;
      $display("FAIL rst_tens_direct cycle=%0d got=%0h want=0", cyc, tens);
    end
    total++;
    if (an !== 2'b01) begin
      bad++;
      $display("FAIL rst_an_direct cycle=%0d got=%0h want=1", cyc, an);
    end
    total++;
    if (seg !== 7'h3F) begin
      bad++;
      $display("FAIL rst_seg_direct cycle=%0d got=%0h want=3f", cyc, seg);
    end
    total++;
    if (carry_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_carry_direct cycle=%0d got=%0h want=0", cyc, carry_out);
    end
    ex(0, "rst_tens",  SIG_TENS,  0);
    ex(0, "rst_uq",    SIG_UQ,    0);
    ex(0, "rst_an",    SIG_AN,    1);
    ex(0, "rst_seg",   SIG_SEG,   'h3F);
    ex(0, "rst_carry", SIG_CARRY, 0);
    ex(0, "rst_bad",   SIG_BAD,   0);
    tick(0);
    @(negedge clk);
    @(posedge clk);
    #1;
    clear = 1'b1;
    rel0  = cyc;
    ex(2, "lat_uq_hold", SIG_UQ, 0);
    ex(3, "lat_uq_7",    SIG_UQ, 7);
    tick(4);

    // Count 0..9 then 0
    for (int v = 0; v <= 9; v++) begin
      units = 4'(v);
      ex(3, "cnt_uq",   SIG_UQ,   v);
      ex(3, "cnt_tens", SIG_TENS, 0);
      tick(4);
    end
    units = 4'd0;
    ex(2, "cnt_tens_pre",  SIG_TENS,  0);
    ex(3, "cnt_tens_inc",  SIG_TENS,  1);
    ex(3, "cnt_uq_0",      SIG_UQ,    0);
    ex(3, "cnt_carry",     SIG_CARRY, 0);
    ex(4, "cnt_carry_nxt", SIG_CARRY, 0);
    ex(5, "cnt_tens_once", SIG_TENS,  1);
    tick(6);

    // Cascade: tens 1 -> 9, then wrap with carry
    repeat (8) wrap();
    ex(0, "cas_tens9", SIG_TENS, 9);
    units = 4'd9;
    tick(4);
    units = 4'd0;
    ex(2, "cas_carry_pre",  SIG_CARRY, 0);
    ex(3, "cas_carry",      SIG_CARRY, 1);
    ex(3, "cas_tens0",      SIG_TENS,  0);
    ex(4, "cas_carry_post", SIG_CARRY, 0);
    ex(4, "cas_tens0_hold", SIG_TENS,  0);
    tick(4);

    // Glitch filter: one-cycle 10 between 9 and 0
    units = 4'd9;
    tick(4);
    units = 4'd10;
    ex(1, "gl_bad1", SIG_BAD, 0);
    ex(2, "gl_bad2", SIG_BAD, 0);
    ex(3, "gl_bad3", SIG_BAD, 0);
    ex(4, "gl_bad4", SIG_BAD, 0);
    ex(3, "gl_uq9",  SIG_UQ,  9);
    ex(4, "gl_uq0",  SIG_UQ,  0);
    ex(3, "gl_tens_pre", SIG_TENS, 0);
    ex(4, "gl_tens_inc", SIG_TENS, 1);
    tick(1);
    units = 4'd0;
    tick(4);

    // Invalid code held, units digit shows dash
    align0();
    units = 4'd12;
    ex(3, "inv_bad",      SIG_BAD,  1);
    ex(3, "inv_uq",       SIG_UQ,   12);
    ex(3, "inv_seg_dash", SIG_SEG,  'h40);
    ex(3, "inv_an_u",     SIG_AN,   1);
    ex(4, "inv_seg_tens", SIG_SEG,  'h06);
    ex(4, "inv_an_t",     SIG_AN,   2);
    ex(5, "inv_tens",     SIG_TENS, 1);
    tick(5);
    units = 4'd0;
    ex(3, "inv0_uq",   SIG_UQ,   0);
    ex(3, "inv0_bad",  SIG_BAD,  0);
    ex(3, "inv0_tens", SIG_TENS, 1);
    ex(4, "inv0_tens2", SIG_TENS, 1);
    tick(5);

    // Scan with tens=3, units=5
    repeat (2) wrap();
    units = 4'd5;
    tick(4);
    align0();
    for (int d = 1; d <= 8; d++) begin
      if (d >= 4 && d <= 7) begin
        ex(d, "scan_seg_t", SIG_SEG, 'h4F);
        ex(d, "scan_an_t",  SIG_AN,  2);
      end else begin
        ex(d, "scan_seg_u", SIG_SEG, 'h6D);
        ex(d, "scan_an_u",  SIG_AN,  1);
      end
    end
    ex(8, "scan_tens3", SIG_TENS, 3);
    tick(8);

    // tens back to 0: leading-zero handling
    repeat (7) wrap();
    units = 4'd5;
    tick(4);
    align0();
    ex(3, "lz_seg_u",  SIG_SEG,  'h6D);
    ex(4, "lz_seg_t",  SIG_SEG,  TENS0_SEG);
    ex(4, "lz_an_t",   SIG_AN,   2);
    ex(7, "lz_seg_t2", SIG_SEG,  TENS0_SEG);
    ex(8, "lz_seg_u2", SIG_SEG,  'h6D);
    ex(8, "lz_tens0",  SIG_TENS, 0);
    tick(8);

    // Mid-operation reset coinciding with a pending 9->0 wrap at tens=9
    repeat (9) wrap();
    units = 4'd9;
    tick(4);
    units = 4'd0;
    ex(2, "mr_tens9", SIG_TENS, 9);
    tick(2);
    total++;
    if (tens !== 4'd9) begin
      bad++;
      $display("FAIL mr_tens9_direct cycle=%0d got=%0h want=9", cyc, tens);
    end
    clear = 1'b0;
    ex(1, "mr_tens",  SIG_TENS,  0);
    ex(1, "mr_carry", SIG_CARRY, 0);
    ex(1, "mr_an",    SIG_AN,    1);
    ex(1, "mr_seg",   SIG_SEG,   'h3F);
    ex(1, "mr_uq",    SIG_UQ,    0);
    tick(1);
    total++;
    if (tens !== 4'd0 || carry_out !== 1'b0 || an !== 2'b01) begin
      bad++;
      $display("FAIL mr_direct cycle=%0d got=%0h/%0h/%0h want=0/0/1", cyc,
               tens, carry_out, an);
    end
    clear = 1'b1;
    rel0  = cyc;
    ex(1, "mr_carry_post", SIG_CARRY, 0);
    ex(3, "mr_an_u",       SIG_AN,    1);
    ex(4, "mr_an_t",       SIG_AN,    2);
    ex(4, "mr_seg_t",      SIG_SEG,   TENS0_SEG);
    ex(5, "mr_tens_hold",  SIG_TENS,  0);
    tick(8);

    @(negedge clk);
    foreach (q[i]) begin
      total++;
      bad++;
      $display("FAIL %s cycle=%0d got=unchecked want=%0h", q[i].nm, q[i].at, q[i].val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
